// File: rtl/btn_pkg.sv
// Shared defaults for the button conditioner: ULX3S button map, 25 MHz timing,
// a fast parameter set for simulation, and the per-channel event record.
package btn_pkg;

  localparam int         BTN_N                  = 7;
  localparam logic [6:0] BTN_ACTIVE_LOW_MASK    = 7'b0000001;  // btn[0] PWR idles high
  localparam int         BTN_TICK_DIV_DEF       = 25000;       // 1 ms at 25 MHz
  localparam int         BTN_DEBOUNCE_TICKS_DEF = 10;
  localparam int         BTN_REPEAT_DELAY_DEF   = 400;
  localparam int         BTN_REPEAT_RATE_DEF    = 66;

  localparam int         BTN_SIM_TICK_DIV       = 4;
  localparam int         BTN_SIM_DEBOUNCE_TICKS = 3;
  localparam int         BTN_SIM_REPEAT_DELAY   = 5;
  localparam int         BTN_SIM_REPEAT_RATE    = 2;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic rpt;
  } btn_evt_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF sync, polarity fix, tick-based debounce, edge pulses.
// Auto-repeat counter exists only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter bit ACTIVE_LOW     = 1'b0,
  parameter int DEBOUNCE_TICKS = BTN_DEBOUNCE_TICKS_DEF,
  parameter int REPEAT_DELAY   = BTN_REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE    = BTN_REPEAT_RATE_DEF
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     tick_i,
  input  logic     raw_i,
  output btn_evt_t evt_o
);

  if (DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("btn_debounce_ch: DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_RATE must be >= 1");
  end

  localparam int             DBW     = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_TICKS - 1);

  logic           sync1_q, sync2_q, norm;
  logic           level_q, level_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           press_q, rel_q;

  // A single matching sample, tick or not, restarts the window.
  always_comb begin
    norm     = sync2_q ^ ACTIVE_LOW;
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    if (norm == level_q) begin
      db_cnt_d = '0;
    end else if (tick_i) begin
      if (db_cnt_q == DB_LAST) begin
        level_d  = ~level_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Sync flops reset to the idle pin level so norm starts at 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= ACTIVE_LOW;
      sync2_q  <= ACTIVE_LOW;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= level_d & ~level_q;
      rel_q    <= ~level_d & level_q;
    end
  end

  assign evt_o.level = level_q;
  assign evt_o.press = press_q;
  assign evt_o.rel   = rel_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int            RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int            RW   = $clog2(RMAX) + 1;

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_fire, rpt_q;

  // Gating on level_d drops a repeat that lands on the release tick.
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_fire  = 1'b0;
    if (!level_d) begin
      rpt_cnt_d = '0;
    end else if (!level_q) begin
      rpt_cnt_d = RW'(REPEAT_DELAY - 1);
    end else if (tick_i) begin
      if (rpt_cnt_q == '0) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = RW'(REPEAT_RATE - 1);
      end else begin
        rpt_cnt_d = rpt_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rpt_cnt_q <= '0;
      rpt_q     <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_q     <= rpt_fire;
    end
  end

  assign evt_o.rpt = rpt_q;
`else
  assign evt_o.rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Button input stage: shared ms-scale tick plus N_BTN debounced channels with
// level, press/release pulses and (BTN_AUTOREPEAT_EN) auto-repeat pulses.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int               N_BTN           = BTN_N,
  parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = N_BTN'(BTN_ACTIVE_LOW_MASK),
  parameter int               TICK_DIV        = BTN_TICK_DIV_DEF,
  parameter int               DEBOUNCE_TICKS  = BTN_DEBOUNCE_TICKS_DEF,
  parameter int               REPEAT_DELAY    = BTN_REPEAT_DELAY_DEF,
  parameter int               REPEAT_RATE     = BTN_REPEAT_RATE_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_BTN-1:0] btn_raw,
  output logic             tick,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("btn_conditioner: TICK_DIV must be >= 2");
  end

  localparam int            CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic          tick_q;

  assign div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

  // First tick lands TICK_DIV clocks after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= (div_q == DIV_LAST);
    end
  end

  assign tick = tick_q;

  btn_evt_t [N_BTN-1:0] evt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .ACTIVE_LOW     (ACTIVE_LOW_MASK[i]),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk_i  (clk),
      .rst_ni (resetn),
      .tick_i (tick_q),
      .raw_i  (btn_raw[i]),
      .evt_o  (evt[i])
    );

    assign btn_level[i]   = evt[i].level;
    assign btn_press[i]   = evt[i].press;
    assign btn_release[i] = evt[i].rel;
    assign btn_repeat[i]  = evt[i].rpt;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner using the fast simulation parameters.
// Repeat expectations follow BTN_AUTOREPEAT_EN as compiled.
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int            N    = BTN_N;
  localparam int            TD   = BTN_SIM_TICK_DIV;
  localparam int            DB   = BTN_SIM_DEBOUNCE_TICKS;
  localparam int            RD   = BTN_SIM_REPEAT_DELAY;
  localparam int            RR   = BTN_SIM_REPEAT_RATE;
  localparam logic [N-1:0]  MASK = BTN_ACTIVE_LOW_MASK;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] btn_raw;
  logic         tick;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

  btn_conditioner #(
    .N_BTN           (N),
    .ACTIVE_LOW_MASK (MASK),
    .TICK_DIV        (TD),
    .DEBOUNCE_TICKS  (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .btn_raw     (btn_raw),
    .tick        (tick),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: edges since reset, pin history, mismatching-tick runs,
  // ticks held since press.
  int           m_n;
  logic         m_tick;
  logic [N-1:0] m_h1, m_h2, m_level, m_press, m_rel, m_rep;
  int           m_run  [N];
  int           m_held [N];

  task automatic m_reset();
    m_n = 0; m_tick = 1'b0;
    m_h1 = MASK; m_h2 = MASK;
    m_level = '0; m_press = '0; m_rel = '0; m_rep = '0;
    for (int i = 0; i < N; i++) begin m_run[i] = 0; m_held[i] = 0; end
  endtask

  task automatic m_step();
    logic         tk;
    logic [N-1:0] norm;
    tk   = (m_n > 0) && (m_n % TD == 0);
    norm = m_h2 ^ MASK;
    m_press = '0; m_rel = '0; m_rep = '0;
    for (int i = 0; i < N; i++) begin
      if (norm[i] == m_level[i]) m_run[i] = 0;
      else if (tk) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_run[i] = 0;
          m_level[i] = ~m_level[i];
          if (m_level[i]) m_press[i] = 1'b1; else m_rel[i] = 1'b1;
        end
      end
`ifdef BTN_AUTOREPEAT_EN
      if (m_press[i]) m_held[i] = 0;
      else if (m_level[i] && tk) begin
        m_held[i]++;
        if (m_held[i] >= RD && (m_held[i] - RD) % RR == 0) m_rep[i] = 1'b1;
      end
`endif
    end
    m_h2 = m_h1; m_h1 = btn_raw; m_n++;
    m_tick = (m_n % TD == 0);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) m_reset(); else m_step();
    end
  end

  int press_cnt [N];
  int rel_cnt   [N];
  int rep_total = 0;
  int rep_low   = 0;
  int press_edge3 = 0;
  int rep_edges [$];

  initial begin
    for (int i = 0; i < N; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      chk("tick",    32'(tick),        32'(m_tick));
      chk("level",   32'(btn_level),   32'(m_level));
      chk("press",   32'(btn_press),   32'(m_press));
      chk("release", 32'(btn_release), 32'(m_rel));
      chk("repeat",  32'(btn_repeat),  32'(m_rep));
      for (int i = 0; i < N; i++) begin
        if (btn_press[i])   press_cnt[i]++;
        if (btn_release[i]) rel_cnt[i]++;
      end
      rep_total += $countones(btn_repeat);
      if (btn_repeat[3]) begin
        rep_edges.push_back(m_n);
        if (!btn_level[3]) rep_low++;
      end
      if (btn_press[3]) press_edge3 = m_n;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    resetn  = 1'b0;
    btn_raw = MASK;
    step(3);
    chk("reset_outputs", {tick, btn_level, btn_press, btn_release, btn_repeat}, '0);
    resetn = 1'b1;

    // 1: idle after reset, tick on edges 4, 8, ...
    step(3);  chk("tick_e3", 32'(tick), 0);
    step(1);  chk("tick_e4", 32'(tick), 1);
    step(1);  chk("tick_e5", 32'(tick), 0);
    step(3);  chk("tick_e8", 32'(tick), 1);
    step(92);
    chk("idle_events", press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1] + rep_total, 0);
    chk("idle_level", 32'(btn_level), 0);

    // 2: press/release on ch1, raw edge just after edge 100
    btn_raw[1] = 1'b1;
    step(12); chk("press1_e112", 32'(btn_press), 0);
    step(1);  chk("press1_e113", 32'(btn_press), 32'h02);
    step(1);  chk("press1_e114", 32'(btn_press), 0);
              chk("level1_held", 32'(btn_level), 32'h02);
    step(6);
    btn_raw[1] = 1'b0;
    step(13); chk("release1_e133", 32'(btn_release), 32'h02);
              chk("level1_low", 32'(btn_level), 0);

    // 3: bounce shorter than the window on ch2
    for (int k = 0; k < 10; k++) begin
      btn_raw[2] = ~btn_raw[2];
      step(6);
    end
    chk("bounce_press2", press_cnt[2], 0);
    chk("bounce_rel2",   rel_cnt[2], 0);
    btn_raw[2] = 1'b1;
    step(30);
    chk("hold_press2", press_cnt[2], 1);
    btn_raw[2] = 1'b0;
    step(30);

    // 4: active-low ch0
    btn_raw[0] = 1'b0;
    step(30);
    chk("press0",  press_cnt[0], 1);
    chk("level0",  32'(btn_level[0]), 1);
    btn_raw[0] = 1'b1;
    step(30);
    chk("rel0",    rel_cnt[0], 1);
    chk("level0_low", 32'(btn_level[0]), 0);

    // 5: hold ch3 for well over 20 ticks, then release
    rep_edges.delete();
    btn_raw[3] = 1'b1;
    step(100);
    btn_raw[3] = 1'b0;
    step(30);
    chk("press3", press_cnt[3], 1);
    chk("rel3",   rel_cnt[3], 1);
`ifdef BTN_AUTOREPEAT_EN
    chk("rep_seen", 32'(rep_edges.size() >= 2), 1);
    if (rep_edges.size() >= 2) begin
      chk("rep_first_delay", rep_edges[0] - press_edge3, 5 * TD);
      chk("rep_period",      rep_edges[1] - rep_edges[0], 2 * TD);
    end
`else
    chk("rep_off", rep_total, 0);
`endif
    chk("rep_after_release", rep_low, 0);

    // 6: reset mid-debounce, then coincident presses
    btn_raw[6] = 1'b1;
    step(30);
    chk("level6", 32'(btn_level[6]), 1);
    for (int g = 0; g < TD && (m_n % TD) != 0; g++) step(1);
    btn_raw[4] = 1'b1;
    btn_raw[5] = 1'b1;
    step(10);
    chk("partial_no_press", 32'(btn_level[5:4]), 0);
    resetn = 1'b0;
    #1;
    chk("async_reset", {tick, btn_level, btn_press, btn_release, btn_repeat}, '0);
    step(2);
    resetn = 1'b1;
    step(12); chk("rst_press_e12", 32'(btn_press), 0);
              chk("rst_level_e12", 32'(btn_level), 0);
    step(1);  chk("rst_press_e13", 32'(btn_press), 32'h70);
    step(1);  chk("rst_level_e14", 32'(btn_level), 32'h70);

    btn_raw = MASK;
    step(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
